// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack sequencer.
// Holds the default geometry (DATA_W/DEPTH), the access opcode encoding and
// the FSM state enum used by the top level.
// Optional feature macro: STACK_SEQ_PEEK_EN (enables the peek operation).
package stack_sequencer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_PEEK = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/stack_sequencer_if.sv
// Bundle of every non-clock/reset signal of the stack sequencer.
//   requester side : clear, req0/1, op0/1, wdata0/1 -> gnt0/1, done0/1,
//                    rvalid0/1, err0/1, rdata
//   memory side    : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
//   status         : count, full, empty, ovf, udf
// slave  = the sequencer, master = requesters + RAM (e.g. a testbench).
interface stack_sequencer_if
  import stack_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              clear;
  logic              req0, req1;
  logic [1:0]        op0, op1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, done0, done1, rvalid0, rvalid1, err0, err1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en, mem_we;
  logic [PTR_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [PTR_W:0]    count;
  logic              full, empty, ovf, udf;

  modport slave (
    input  clear, req0, req1, op0, op1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rvalid0, rvalid1, err0, err1, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, count, full, empty, ovf, udf
  );

  modport master (
    output clear, req0, req1, op0, op1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rvalid0, rvalid1, err0, err1, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, count, full, empty, ovf, udf
  );

endinterface

// File: rtl/stack_rr_arb.sv
// Two-way round-robin arbiter.
//   req0/req1 : requests
//   last      : 1 when requester 1 was granted most recently
//   gnt0/gnt1 : one-hot (or zero) grant
module stack_rr_arb (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);
  // On a tie the requester that was not served last wins.
  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);
endmodule

// File: rtl/stack_sequencer.sv
// Stack sequencer: two requesters share one LIFO stored in an external
// single-port RAM (1-cycle read latency).
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : stack_sequencer_if.slave (requests, responses, RAM port, status)
// Optional feature macro: STACK_SEQ_PEEK_EN -- when undefined, op 10 (peek)
// is handled like the reserved opcode.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  stack_sequencer_if.slave bus
);
  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_e            state, state_nx;
  logic [PTR_W:0]    sp, sp_m1;
  logic              last, owner, is_pop, ovf_q, udf_q;
  logic [DATA_W-1:0] wdata_q;
  logic              arb_g0, arb_g1, grant, gsel, full, empty;
  op_e               gop;
  logic [DATA_W-1:0] gwdata;
  logic              go_wr, go_rd, rd_pop, set_ovf, set_udf;

  stack_rr_arb u_arb (
    .req0 (bus.req0),
    .req1 (bus.req1),
    .last (last),
    .gnt0 (arb_g0),
    .gnt1 (arb_g1)
  );

  // Grants exist only in IDLE, and a pending flush suppresses them.
  assign grant  = (state == IDLE) && !bus.clear && (arb_g0 || arb_g1);
  assign gsel   = arb_g1;
  assign gop    = op_e'(gsel ? bus.op1 : bus.op0);
  assign gwdata = gsel ? bus.wdata1 : bus.wdata0;
  assign sp_m1  = sp - ONE;
  assign full   = (sp == FULL_CNT);
  assign empty  = (sp == '0);

  assign bus.count = sp;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;

  // Classify the granted operation; anything not accepted ends in ERR.
  always_comb begin
    go_wr   = 1'b0;
    go_rd   = 1'b0;
    rd_pop  = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    case (gop)
      OP_PUSH: if (full) set_ovf = 1'b1; else go_wr = 1'b1;
      OP_POP:  if (empty) set_udf = 1'b1; else begin go_rd = 1'b1; rd_pop = 1'b1; end
`ifdef STACK_SEQ_PEEK_EN
      OP_PEEK: if (empty) set_udf = 1'b1; else go_rd = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.done0     = 1'b0;
    bus.done1     = 1'b0;
    bus.rvalid0   = 1'b0;
    bus.rvalid1   = 1'b0;
    bus.err0      = 1'b0;
    bus.err1      = 1'b0;
    bus.rdata     = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: if (grant) begin
        bus.gnt0 = arb_g0;
        bus.gnt1 = arb_g1;
        state_nx = go_wr ? WR : (go_rd ? RD : ERR);
      end
      WR: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = sp[PTR_W-1:0];
        bus.mem_wdata = wdata_q;
        bus.done0     = !owner;
        bus.done1     = owner;
        state_nx      = IDLE;
      end
      RD: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = sp_m1[PTR_W-1:0];
        state_nx     = RESP;
      end
      RESP: begin
        bus.rdata   = bus.mem_rdata;
        bus.rvalid0 = !owner;
        bus.rvalid1 = owner;
        state_nx    = IDLE;
      end
      ERR: begin
        bus.err0 = !owner;
        bus.err1 = owner;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp      <= '0;
      last    <= 1'b1;
      owner   <= 1'b0;
      is_pop  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (state == IDLE && bus.clear) begin
        sp    <= '0;
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else if (grant) begin
        last   <= gsel;
        owner  <= gsel;
        is_pop <= rd_pop;
        if (go_wr)   wdata_q <= gwdata;
        if (set_ovf) ovf_q   <= 1'b1;
        if (set_udf) udf_q   <= 1'b1;
      end
      if (state == WR)           sp <= sp + ONE;
      if (state == RD && is_pop) sp <= sp_m1;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed scenarios plus random
// operations compared against a queue-based stack model.
module tb_stack_sequencer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_sequencer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) b ();

  stack_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  // Single-port RAM with one cycle of read latency.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (b.mem_en) begin
      if (b.mem_we) ram[b.mem_addr] <= b.mem_wdata;
      else          b.mem_rdata     <= ram[b.mem_addr];
    end
  end

  // Reference model
  logic [DATA_W-1:0] stk [$];
  logic ovf_m, udf_m, last_m;

  int total = 0, pass = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, b.count, stk.size());
    chk({tag, "_full"},  b.full,  stk.size() == DEPTH);
    chk({tag, "_empty"}, b.empty, stk.size() == 0);
    chk({tag, "_ovf"},   b.ovf,   ovf_m);
    chk({tag, "_udf"},   b.udf,   udf_m);
  endtask

  task automatic model_reset();
    stk.delete();
    ovf_m = 1'b0; udf_m = 1'b0; last_m = 1'b1;
  endtask

  task automatic wait_gnt(input int who, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(who == 0 ? b.gnt0 : b.gnt1) && n < 8) begin @(negedge clk); n++; end
    chk({tag, "_gnt"},   who == 0 ? b.gnt0 : b.gnt1, 1);
    chk({tag, "_gnt_x"}, who == 0 ? b.gnt1 : b.gnt0, 0);
  endtask

  // One complete operation from one requester, checked stage by stage.
  // kind: 0 push accepted, 1 read accepted, 2 rejected
  task automatic op_run(input int who, input logic [1:0] op, input logic [7:0] d, input string tag);
    int kind; bit popit; logic [7:0] top;
    popit = 0;
    @(posedge clk); #1;
    if (who == 0) begin b.req0 = 1; b.op0 = op; b.wdata0 = d; end
    else          begin b.req1 = 1; b.op1 = op; b.wdata1 = d; end
    wait_gnt(who, tag);
    last_m = who[0];
    if (op == 2'b00) begin
      if (stk.size() < DEPTH) kind = 0; else begin kind = 2; ovf_m = 1; end
    end else if (op == 2'b01) begin
      if (stk.size() > 0) begin kind = 1; popit = 1; end else begin kind = 2; udf_m = 1; end
    end else if (op == 2'b10) begin
`ifdef STACK_SEQ_PEEK_EN
      if (stk.size() > 0) kind = 1; else begin kind = 2; udf_m = 1; end
`else
      kind = 2;
`endif
    end else kind = 2;
    @(posedge clk); #1;
    b.req0 = 0; b.req1 = 0;
    @(negedge clk);
    if (kind == 0) begin
      chk({tag, "_wr_en"},   b.mem_en, 1);
      chk({tag, "_wr_we"},   b.mem_we, 1);
      chk({tag, "_wr_addr"}, b.mem_addr, stk.size());
      chk({tag, "_wr_data"}, b.mem_wdata, d);
      chk({tag, "_done"},    who == 0 ? b.done0 : b.done1, 1);
      chk({tag, "_done_x"},  who == 0 ? b.done1 : b.done0, 0);
      stk.push_back(d);
    end else if (kind == 1) begin
      top = stk[$];
      chk({tag, "_rd_en"},   b.mem_en, 1);
      chk({tag, "_rd_we"},   b.mem_we, 0);
      chk({tag, "_rd_addr"}, b.mem_addr, stk.size() - 1);
      chk({tag, "_rv_early"}, b.rvalid0 | b.rvalid1, 0);
      @(negedge clk);
      chk({tag, "_rvalid"},   who == 0 ? b.rvalid0 : b.rvalid1, 1);
      chk({tag, "_rvalid_x"}, who == 0 ? b.rvalid1 : b.rvalid0, 0);
      chk({tag, "_rdata"},    b.rdata, top);
      if (popit) void'(stk.pop_back());
    end else begin
      chk({tag, "_err"},    who == 0 ? b.err0 : b.err1, 1);
      chk({tag, "_err_x"},  who == 0 ? b.err1 : b.err0, 0);
      chk({tag, "_err_en"}, b.mem_en, 0);
    end
    @(negedge clk);
    chk_status(tag);
  endtask

  task automatic do_clear(input string tag);
    @(posedge clk); #1;
    b.clear = 1;
    @(negedge clk);
    chk({tag, "_nognt"}, b.gnt0 | b.gnt1, 0);
    @(posedge clk); #1;
    b.clear = 0; b.req0 = 0; b.req1 = 0;
    stk.delete(); ovf_m = 0; udf_m = 0;
    @(negedge clk);
    chk_status(tag);
  endtask

  initial begin
    b.clear = 0; b.req0 = 0; b.req1 = 0; b.op0 = 0; b.op1 = 0;
    b.wdata0 = 0; b.wdata1 = 0; b.mem_rdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_en",  b.mem_en, 0);
    chk("rst_out", {b.gnt0, b.gnt1, b.done0, b.done1, b.rvalid0, b.rvalid1, b.err0, b.err1}, 0);
    chk("rst_rdata", b.rdata, 0);
    chk_status("rst");
    @(posedge clk); #1 rst = 1;

    // First push lands at address 0
    op_run(0, 2'b00, 8'hA5, "push_a5");
    do_clear("clr1");

    // Push two, pop from requester 1
    op_run(0, 2'b00, 8'h11, "push_11");
    op_run(0, 2'b00, 8'h22, "push_22");
    op_run(1, 2'b01, 8'h00, "pop_22");

    // Peek (or reserved when peek is disabled), then reserved opcode
    op_run(0, 2'b00, 8'h3C, "push_3c");
    op_run(1, 2'b10, 8'h00, "peek_3c");
    op_run(0, 2'b11, 8'h00, "rsvd");

    // Clear wins over a simultaneous request
    @(posedge clk); #1;
    b.clear = 1; b.req0 = 1; b.op0 = 2'b00; b.wdata0 = 8'h77;
    @(negedge clk);
    chk("clrbeat_gnt", b.gnt0, 0);
    @(posedge clk); #1;
    b.clear = 0; b.req0 = 0;
    stk.delete(); ovf_m = 0; udf_m = 0;
    @(negedge clk);
    chk_status("clrbeat");

    // Fill, overflow, clear, underflow, clear
    for (int i = 0; i < DEPTH; i++) op_run(i % 2, 2'b00, 8'($urandom), "fill");
    op_run(0, 2'b00, 8'hEE, "ovf");
    do_clear("clr_ovf");
    op_run(1, 2'b01, 8'h00, "udf");
    do_clear("clr_udf");

    // Reset asserted while in RD
    op_run(0, 2'b00, 8'h5A, "push_5a");
    @(posedge clk); #1;
    b.req1 = 1; b.op1 = 2'b01;
    wait_gnt(1, "rstrd");
    @(posedge clk); #1;
    b.req1 = 0; rst = 0;
    model_reset();
    @(negedge clk);
    chk("rstrd_rv",  b.rvalid0 | b.rvalid1, 0);
    chk("rstrd_en",  b.mem_en, 0);
    chk_status("rstrd");
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("rstrd_rv2", b.rvalid0 | b.rvalid1, 0);
    chk_status("rstrd2");

    // Both requesters held: grants alternate starting with 0 after reset
    @(posedge clk); #1;
    b.req0 = 1; b.op0 = 2'b00; b.wdata0 = 8'hB0;
    b.req1 = 1; b.op1 = 2'b00; b.wdata1 = 8'hB1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      @(negedge clk);
      while (!(b.gnt0 | b.gnt1) && n < 8) begin @(negedge clk); n++; end
      chk("alt_gnt0", b.gnt0, (k % 2) == 0);
      chk("alt_gnt1", b.gnt1, (k % 2) == 1);
      last_m = k[0];
      stk.push_back(k[0] ? 8'hB1 : 8'hB0);
      @(posedge clk);
    end
    #1 b.req0 = 0; b.req1 = 0;
    @(negedge clk);
    @(negedge clk);
    chk_status("alt");
    do_clear("clr_alt");

    // Random operations
    for (int i = 0; i < 60; i++) begin
      int r; logic [1:0] op;
      r = int'($urandom_range(0, 9));
      op = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      op_run(int'($urandom_range(0, 1)), op, 8'($urandom), "rnd");
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
